fetch_stage: RTL and testbench

Instruction fetch front end for the pipelined RV32I core: owns the PC, issues word reads to the instruction memory (fixed 1-cycle read latency), buffers returned words in a 2-entry queue, and hands {pc, inst} to decode under a valid/ready handshake. It sits directly upstream of decode. It accepts branch/jump redirects from execute and stops on a halt request.

---
 rtl/core_pkg.sv | 11 +
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_buf.sv | 39 +++
 rtl/fetch_stage.sv | 75 +++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared widths, constants and fetch packet type for the RV32I core.
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef logic [XLEN-1:0] word_t;
  typedef struct packed {
    word_t pc;
    word_t inst;
  } fetch_pkt_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: imem read port, decode handshake and control lines of the fetch stage.
interface fetch_stage_if;
  import core_pkg::*;
  logic  imem_req;
  word_t imem_addr;
  word_t imem_rdata;
  logic  id_valid;
  logic  id_ready;
  word_t id_pc;
  word_t id_inst;
  logic  redirect;
  word_t redirect_pc;
  logic  halt_req;
  logic  halted;
  logic  fault;
  modport master (
    output imem_req, imem_addr, id_valid, id_pc, id_inst, halted, fault,
    input  imem_rdata, id_ready, redirect, redirect_pc, halt_req
  );
  modport slave (
    input  imem_req, imem_addr, id_valid, id_pc, id_inst, halted, fault,
    output imem_rdata, id_ready, redirect, redirect_pc, halt_req
  );
endinterface

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry {pc, inst} FIFO; flush beats push in the same cycle.
module fetch_buf
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  fetch_pkt_t i_pkt,
  output logic [1:0] o_count,
  output fetch_pkt_t o_head
);
  fetch_pkt_t r_mem [2];
  logic       r_rd;
  logic       r_wr;
  logic [1:0] r_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_wr <= ~r_wr;
      if (i_pop) r_rd <= ~r_rd;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end
  // storage needs no reset: contents are only visible while r_count != 0
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_pkt;
  end
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner issuing 1-cycle imem reads, buffering words and presenting {pc, inst} to decode.
module fetch_stage
  import core_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);
  word_t      r_pc;
  word_t      r_req_pc;
  logic       r_inflight;
  logic       r_drop;
  logic       r_halted;
  logic       r_fault;
  logic [1:0] w_count;
  fetch_pkt_t w_head;
  logic       w_redir;
  logic       w_mis;
  logic       w_valid;
  logic       w_pop;
  logic       w_issue;
  logic       w_push;
  always_comb begin
    w_redir = bus.redirect && !r_halted && !bus.halt_req;
    w_mis   = w_redir && (bus.redirect_pc[1:0] != 2'b00);
    w_valid = (w_count != 2'd0) && !bus.redirect && !r_halted;
    w_pop   = w_valid && bus.id_ready;
    // rst gate keeps the strobe low for the whole reset, not just after the first edge
    w_issue = !rst && !r_halted && !bus.redirect && ((w_count + {1'b0, r_inflight} < 2'd2) || w_pop);
    w_push  = r_inflight && !r_drop;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_drop     <= 1'b0;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_drop     <= w_redir && r_inflight;
      if (w_issue) begin
        r_pc     <= r_pc + 32'd4;
        r_req_pc <= r_pc;
      end
      if (w_mis) begin
        r_fault  <= 1'b1;
        r_halted <= 1'b1;
      end else if (w_redir) begin
        r_pc <= bus.redirect_pc;
      end
      if (bus.halt_req) r_halted <= 1'b1;
    end
  end
  fetch_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redir),
    .i_pkt   ({r_req_pc, bus.imem_rdata}),
    .o_count (w_count),
    .o_head  (w_head)
  );
  assign bus.imem_req  = w_issue;
  assign bus.imem_addr = r_pc;
  assign bus.id_valid  = w_valid;
  assign bus.id_pc     = w_valid ? w_head.pc : '0;
  assign bus.id_inst   = w_valid ? w_head.inst : NOP_INST;
  assign bus.halted    = r_halted;
  assign bus.fault     = r_fault;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a scoreboard of expected {pc, inst} deliveries.
module tb_fetch_stage;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } pair_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  int n_req = 0;
  logic saw200 = 1'b0;
  pair_t sb[$];
  fetch_stage_if bus ();
  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= bus.imem_addr >> 2;
  end
  always @(posedge clk) begin
    if (!rst && bus.imem_req) n_req <= n_req + 1;
    if (!rst && bus.imem_req && bus.imem_addr == 32'h0000_0200) saw200 <= 1'b1;
  end
  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endfunction
  function automatic void chk1(string nm, logic got, logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
    end
  endfunction
  function automatic void exp_push(logic [31:0] pc, logic [31:0] inst);
    pair_t p;
    p.pc = pc;
    p.inst = inst;
    sb.push_back(p);
  endfunction
  always @(negedge clk) begin
    if (!rst && bus.id_valid && bus.id_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra got_pc=%h got_inst=%h exp=none", bus.id_pc, bus.id_inst);
      end else begin
        pair_t e;
        e = sb.pop_front();
        chk("sb_pc", bus.id_pc, e.pc);
        chk("sb_inst", bus.id_inst, e.inst);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.id_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.halt_req = 1'b0;
    bus.redirect_pc = '0;
    #1;
    chk1("rst_req", bus.imem_req, 1'b0);
    chk1("rst_valid", bus.id_valid, 1'b0);
    chk("rst_pc", bus.id_pc, 32'h0);
    chk("rst_inst", bus.id_inst, 32'h0000_0013);
    chk1("rst_halted", bus.halted, 1'b0);
    chk1("rst_fault", bus.fault, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    do_reset();
    bus.id_ready = 1'b1;
    exp_push(32'h0, 32'h0);
    exp_push(32'h4, 32'h1);
    exp_push(32'h8, 32'h2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk1("t1_req", bus.imem_req, 1'b1);
      chk("t1_addr", bus.imem_addr, 32'(c * 4));
      chk1("t1_valid", bus.id_valid, c >= 2);
      tick();
    end
    bus.id_ready = 1'b0;
    exp_push(32'hC, 32'h3);
    exp_push(32'h10, 32'h4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk1("t2_req", bus.imem_req, 1'b0);
      chk1("t2_valid", bus.id_valid, 1'b1);
      chk("t2_head", bus.id_pc, 32'hC);
      tick();
    end
    chk("t2_issued", n_req, 32'd5);
    bus.id_ready = 1'b1;
    @(negedge clk);
    chk("t2_addr20", bus.imem_addr, 32'h14);
    tick();
    @(negedge clk);
    chk("t2_addr24", bus.imem_addr, 32'h18);
    tick();
    bus.id_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    @(negedge clk);
    chk1("t3_r_req", bus.imem_req, 1'b0);
    chk1("t3_r_valid", bus.id_valid, 1'b0);
    tick();
    bus.redirect = 1'b0;
    bus.id_ready = 1'b1;
    exp_push(32'h100, 32'h40);
    exp_push(32'h104, 32'h41);
    @(negedge clk);
    chk1("t3_r1_req", bus.imem_req, 1'b1);
    chk("t3_r1_addr", bus.imem_addr, 32'h100);
    chk1("t3_r1_valid", bus.id_valid, 1'b0);
    tick();
    @(negedge clk);
    chk1("t3_r2_valid", bus.id_valid, 1'b0);
    tick();
    @(negedge clk);
    chk1("t3_r3_valid", bus.id_valid, 1'b1);
    tick();
    tick();
    bus.id_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h102;
    @(negedge clk);
    chk1("t4_req", bus.imem_req, 1'b0);
    tick();
    bus.redirect = 1'b0;
    bus.id_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk1("t4_fault", bus.fault, 1'b1);
      chk1("t4_halted", bus.halted, 1'b1);
      chk1("t4_req_off", bus.imem_req, 1'b0);
      chk1("t4_valid_off", bus.id_valid, 1'b0);
      tick();
    end
    chk("t3_drain", sb.size(), 32'd0);
    do_reset();
    bus.id_ready = 1'b1;
    tick();
    tick();
    bus.halt_req = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    @(negedge clk);
    chk1("t5_req", bus.imem_req, 1'b0);
    tick();
    bus.halt_req = 1'b0;
    bus.redirect = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk1("t5_halted", bus.halted, 1'b1);
      chk1("t5_fault", bus.fault, 1'b0);
      chk1("t5_req_off", bus.imem_req, 1'b0);
      chk1("t5_valid_off", bus.id_valid, 1'b0);
      tick();
    end
    do_reset();
    bus.id_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    exp_push(32'hFFFF_FFF8, 32'h3FFF_FFFE);
    exp_push(32'hFFFF_FFFC, 32'h3FFF_FFFF);
    exp_push(32'h0, 32'h0);
    @(negedge clk);
    chk1("t6_r_req", bus.imem_req, 1'b0);
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("t6_addr0", bus.imem_addr, 32'hFFFF_FFF8);
    tick();
    @(negedge clk);
    chk("t6_addr1", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    chk("t6_addr2", bus.imem_addr, 32'h0);
    chk1("t6_req2", bus.imem_req, 1'b1);
    tick();
    tick();
    tick();
    do_reset();
    chk("t6_drain", sb.size(), 32'd0);
    bus.id_ready = 1'b1;
    exp_push(32'h0, 32'h0);
    exp_push(32'h4, 32'h1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk1("t7_valid", bus.id_valid, c >= 2);
      chk("t7_addr", bus.imem_addr, 32'(c * 4));
      tick();
    end
    bus.id_ready = 1'b0;
    repeat (3) tick();
    chk("t7_drain", sb.size(), 32'd0);
    chk1("t5_no200", saw200, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
